// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver: state encodings,
// divider width and default frame geometry.
package uart_pkg;

   localparam int COUNT_REG_LEN        = 10;
   localparam int DEFAULT_PAYLOAD_BITS = 8;
   localparam int DEFAULT_STOP_BITS    = 1;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP,
      TX_BREAK,
      TX_BRK_MARK
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_BREAK
   } rx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer shared by the UART transmitter and receiver. The divider is
// captured on load, so a frame keeps its bit period even if divider changes.
module uart_bit_timer
   import uart_pkg::*;
(
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [COUNT_REG_LEN-1:0] divider,
   input  logic                     load,
   input  logic                     enable,
   input  logic                     clear,
   output logic                     bit_tick,
   output logic                     half_tick
);

   logic [COUNT_REG_LEN-1:0] div_q;
   logic [COUNT_REG_LEN-1:0] count;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_q <= '0;
         count <= '0;
      end else if (load) begin
         div_q <= divider;
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= (count == div_q) ? '0 : count + COUNT_REG_LEN'(1);
      end
   end

   assign bit_tick  = enable && (count == div_q);
   assign half_tick = enable && (count == (div_q >> 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, PAYLOAD_BITS data bits LSB first, STOP_BITS stop
// bits, plus a BREAK sequence (long low followed by one mark bit).
module uart_tx
   import uart_pkg::*;
#(
   parameter int PAYLOAD_BITS = DEFAULT_PAYLOAD_BITS,
   parameter int STOP_BITS    = DEFAULT_STOP_BITS
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [COUNT_REG_LEN-1:0] divider,
   input  logic                     uart_tx_en,
   input  logic                     uart_tx_valid,
   output logic                     uart_tx_ready,
   input  logic [PAYLOAD_BITS-1:0]  uart_tx_data,
   input  logic                     uart_tx_break,
   output logic                     uart_tx_busy,
   output logic                     uart_txd
);

   localparam logic [3:0] LAST_DATA  = 4'(PAYLOAD_BITS - 1);
   localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);
   localparam logic [3:0] LAST_BREAK = 4'(PAYLOAD_BITS + STOP_BITS);

   tx_state_t               state, state_next;
   logic [PAYLOAD_BITS-1:0] shift_reg;
   logic [3:0]              bit_cnt;
   logic                    txd_next;
   logic                    accept;
   logic                    break_start;
   logic                    bit_tick;
   logic                    half_tick_unused;

   assign uart_tx_ready = resetn && (state == TX_IDLE) && uart_tx_en && !uart_tx_break;
   assign accept        = uart_tx_valid && uart_tx_ready;
   assign break_start   = (state == TX_IDLE) && uart_tx_en && uart_tx_break;
   assign uart_tx_busy  = (state != TX_IDLE);

   // half_tick is the receiver's mid-bit sample point; the transmitter only
   // needs bit boundaries.
   uart_bit_timer u_timer (
      .clk       (clk),
      .resetn    (resetn),
      .divider   (divider),
      .load      (accept || break_start),
      .enable    (uart_tx_busy),
      .clear     (!uart_tx_busy),
      .bit_tick  (bit_tick),
      .half_tick (half_tick_unused)
   );

   // NOTE: every output of this block gets a default first, so no path can
   // leave a variable unassigned and infer a latch.
   always_comb begin
      state_next = state;
      txd_next   = 1'b1;
      case (state)
         TX_IDLE: begin
            if (break_start)  state_next = TX_BREAK;
            else if (accept)  state_next = TX_START;
         end
         TX_START: begin
            txd_next = 1'b0;
            if (bit_tick) state_next = TX_DATA;
         end
         TX_DATA: begin
            txd_next = shift_reg[0];
            if (bit_tick && bit_cnt == LAST_DATA) state_next = TX_STOP;
         end
         TX_STOP: begin
            if (bit_tick && bit_cnt == LAST_STOP) state_next = TX_IDLE;
         end
         TX_BREAK: begin
            txd_next = 1'b0;
            if (bit_tick && bit_cnt == LAST_BREAK) state_next = TX_BRK_MARK;
         end
         TX_BRK_MARK: begin
            if (bit_tick) state_next = TX_IDLE;
         end
         default: state_next = TX_IDLE;
      endcase
   end

   // txd is registered from the current state, so the line lags the FSM by one
   // clock: accept at edge N puts the start bit on the pin at edge N+1.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= TX_IDLE;
         bit_cnt   <= '0;
         shift_reg <= '0;
         uart_txd  <= 1'b1;
      end else begin
         state    <= state_next;
         uart_txd <= txd_next;

         if (state_next != state) bit_cnt <= '0;
         else if (bit_tick)       bit_cnt <= bit_cnt + 4'd1;

         if (accept)                          shift_reg <= uart_tx_data;
         else if (state == TX_DATA && bit_tick) shift_reg <= shift_reg >> 1;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level reference model checked every
// cycle, a behavioural loopback receiver, and literal waveform checks.
module tb_uart_tx;

   localparam int P = 8;
   localparam int S = 1;

   typedef struct {
      logic [7:0] d;
      logic       b;
   } rx_t;

   logic       clk     = 1'b0;
   logic       resetn  = 1'b1;
   logic [9:0] divider = 10'd9;
   logic       en      = 1'b0;
   logic       valid   = 1'b0;
   logic       brk     = 1'b0;
   logic [7:0] data    = 8'h00;
   logic       ready, busy, txd;

   always #5 clk = ~clk;

   uart_tx #(.PAYLOAD_BITS(P), .STOP_BITS(S)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .divider       (divider),
      .uart_tx_en    (en),
      .uart_tx_valid (valid),
      .uart_tx_ready (ready),
      .uart_tx_data  (data),
      .uart_tx_break (brk),
      .uart_tx_busy  (busy),
      .uart_txd      (txd)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // A transaction started at edge N is a list of m_len line levels, each held
   // (m_d+1) cycles starting at edge N+1; busy covers cycles N .. N+m_len*(m_d+1)-1.
   int          m_c   = 0;
   int          m_len = 0;
   logic [9:0]  m_d   = '0;
   logic [15:0] m_bits = '1;
   logic        m_busy, m_txd, m_ready;
   rx_t         exp_q[$];

   function automatic logic [15:0] frame_bits(input logic [7:0] d);
      logic [15:0] b;
      b    = '1;
      b[0] = 1'b0;
      for (int i = 0; i < P; i++) b[i+1] = d[i];
      return b;
   endfunction

   always_comb begin
      m_busy = m_c < m_len * (int'(m_d) + 1);
      m_txd  = 1'b1;
      if (m_c >= 1 && m_c <= m_len * (int'(m_d) + 1))
         m_txd = m_bits[(m_c - 1) / (int'(m_d) + 1)];
      m_ready = resetn && !m_busy && en && !brk;
   end

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_c   <= 0;
         m_len <= 0;
         m_d   <= '0;
         m_bits <= '1;
         exp_q.delete();
      end else if (!m_busy && en && brk) begin
         m_c    <= 0;
         m_len  <= P + S + 2;
         m_d    <= divider;
         m_bits <= 16'(1) << (P + S + 1);
         exp_q.push_back(rx_t'{d: 8'h00, b: 1'b1});
      end else if (!m_busy && en && valid) begin
         m_c    <= 0;
         m_len  <= 1 + P + S;
         m_d    <= divider;
         m_bits <= frame_bits(data);
         exp_q.push_back(rx_t'{d: data, b: 1'b0});
      end else if (m_c < 1000000) begin
         m_c <= m_c + 1;
      end
   end

   always @(negedge clk) begin
      check("txd", {31'd0, txd}, {31'd0, m_txd});
      check("busy", {31'd0, busy}, {31'd0, m_busy});
      check("ready", {31'd0, ready}, {31'd0, m_ready});
   end

   // ---------------- line monitors ----------------
   logic prev_txd   = 1'b1;
   int   low_run    = 0;
   int   last_low   = 0;
   int   since_fall = 0;
   int   fall_gap   = 0;
   int   busy_run   = 0;
   int   last_busy  = 0;

   always @(negedge clk) begin
      prev_txd <= txd;
      low_run  <= txd ? 0 : low_run + 1;
      if (txd && !prev_txd) last_low <= low_run;
      if (!txd && prev_txd) begin
         fall_gap   <= since_fall;
         since_fall <= 1;
      end else begin
         since_fall <= since_fall + 1;
      end
      if (busy) busy_run <= busy_run + 1;
      else if (busy_run != 0) begin
         last_busy <= busy_run;
         busy_run  <= 0;
      end
   end

   // ---------------- loopback receiver ----------------
   logic [15:0] rx_smp;
   logic [7:0]  rx_data;
   logic        rx_brk;
   int          rx_dv, rx_cnt, rx_k;
   bit          rx_abort;
   rx_t         rx_e;
   int          rx_frames = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (resetn && txd === 1'b0) begin
            rx_dv    = int'(divider);
            rx_cnt   = 0;
            rx_abort = 0;
            rx_smp   = '1;
            for (int j = 0; j < P + S + 1 && !rx_abort; j++) begin
               while (!rx_abort && rx_cnt < j * (rx_dv + 1) + rx_dv / 2) begin
                  @(negedge clk);
                  rx_cnt++;
                  if (!resetn) rx_abort = 1;
               end
               rx_smp[j] = txd;
            end
            if (!rx_abort) begin
               rx_data = rx_smp[P:1];
               rx_brk  = (rx_data == 8'h00) && !rx_smp[P+1];
               if (exp_q.size() == 0) begin
                  check("rx unexpected frame", {24'd0, rx_data}, 32'hFFFF_FFFF);
               end else begin
                  rx_e = exp_q.pop_front();
                  check("rx data", {24'd0, rx_data}, {24'd0, rx_e.d});
                  check("rx break", {31'd0, rx_brk}, {31'd0, rx_e.b});
                  rx_frames++;
               end
               if (rx_brk) begin
                  rx_k = 0;
                  while (txd !== 1'b1 && rx_k < 5000) begin
                     @(negedge clk);
                     rx_k++;
                  end
                  if (rx_k >= 5000) check("rx break end timeout", 32'd0, 32'd1);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [7:0] d, input bit hold);
      int k;
      valid = 1'b1;
      data  = d;
      k     = 0;
      forever begin
         @(negedge clk);
         if (m_ready || k >= 5000) break;
         k++;
      end
      if (k >= 5000) check("send timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      if (!hold) valid = 1'b0;
      data = ~d;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int wave_a5[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

   initial begin
      #1 resetn = 1'b0;
      en = 1'b1;
      cycles(3);
      check("reset txd", {31'd0, txd}, 32'd1);
      check("reset ready", {31'd0, ready}, 32'd0);
      check("reset busy", {31'd0, busy}, 32'd0);
      resetn = 1'b1;
      @(negedge clk);
      check("ready after release", {31'd0, ready}, 32'd1);
      cycles(2);

      // single frame 0xA5, 10-cycle bits; sample mid-bit
      divider = 10'd9;
      send(8'hA5, 0);
      #56;
      for (int k = 0; k < 10; k++) begin
         check("a5 bit", {31'd0, txd}, 32'(wave_a5[k]));
         #100;
      end
      cycles(5);
      check("a5 busy cycles", 32'(last_busy), 32'd100);

      // back-to-back with valid held
      send(8'h00, 1);
      send(8'hFF, 0);
      cycles(5);
      check("b2b start gap", 32'(fall_gap), 32'd101);
      cycles(110);

      // break and valid together: break wins
      brk   = 1'b1;
      valid = 1'b1;
      data  = 8'h77;
      @(negedge clk);
      check("break ready", {31'd0, ready}, 32'd0);
      @(posedge clk);
      #1;
      brk   = 1'b0;
      valid = 1'b0;
      cycles(130);
      check("break low cycles", 32'(last_low), 32'd100);
      check("break busy cycles", 32'(last_busy), 32'd110);

      // divider change and enable drop mid-frame
      send(8'h5A, 0);
      cycles(30);
      divider = 10'd4;
      en      = 1'b0;
      valid   = 1'b1;
      data    = 8'hFF;
      cycles(90);
      check("en-low frame busy", 32'(last_busy), 32'd100);
      check("en-low ready", {31'd0, ready}, 32'd0);
      check("en-low busy", {31'd0, busy}, 32'd0);
      en = 1'b1;
      send(8'hFF, 0);
      cycles(60);
      check("new divider start", 32'(last_low), 32'd5);
      check("new divider busy", 32'(last_busy), 32'd50);

      // reset during bit 3 of 0xC3 (bit 3 is 0)
      divider = 10'd9;
      send(8'hC3, 0);
      #356;
      check("bit3 before reset", {31'd0, txd}, 32'd0);
      resetn = 1'b0;
      #1;
      check("async reset txd", {31'd0, txd}, 32'd1);
      check("async reset busy", {31'd0, busy}, 32'd0);
      cycles(3);
      resetn = 1'b1;
      cycles(5);
      send(8'h3C, 0);
      cycles(115);

      check("all frames received", 32'(exp_q.size()), 32'd0);
      check("frame count", 32'(rx_frames), 32'd7);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
